miter_lockstep_checker: RTL and testbench
=========================================

// Module: miter_lockstep_checker
// PURPOSE
// - Cycle-by-cycle lockstep comparator sitting downstream of a gold/gate partition pair (e.g. jpeg_encoder clock-leaf partitions).
// - Consumes gold and gate output buses, ignores gold don't-care bits, counts compares and mismatches, and reports a pass/fail verdict.
// - Synthesizable stand-in for the per-output compare properties, usable in emulation and post-route gate-level simulation.
// PARAMETERS
// - WIDTH      default 32  compared bus width in bits (>=1)
// - CNT_W      default 16  width of compare and error counters
// - WARMUP_CYC default 4   valid beats discarded after start before compares begin (0 = none)
// - FAIL_LIMIT default 1   error count that forces an early verdict (0 = never stop early)
// PORTS
// - clk        in   1      single clock; all state updates on rising edge
// - rst        in   1      synchronous, active-high reset
// - start      in   1      pulse: arm a new check session (accepted only in IDLE or DONE)
// - stop       in   1      pulse: end session and issue verdict
// - cmp_vld    in   1      gold_data/gate_data/gold_xmask valid this cycle
// - gold_data  in   WIDTH  gold partition output
// - gate_data  in   WIDTH  gate partition output
// - gold_xmask in   WIDTH  1 = corresponding gold bit is don't-care (always matches)
// - busy       out  1      session in WARMUP or RUN
// - done       out  1      verdict valid; held until next start or rst
// - pass       out  1      done & err_count==0
// - fail       out  1      err_count!=0; may assert mid-session, sticky until next start or rst
// - cmp_count  out  CNT_W  beats compared in RUN (saturating)
// - err_count  out  CNT_W  mismatching beats (saturating)
// BEHAVIOUR
// - Reset: state=IDLE; busy,done,pass,fail=0; cmp_count,err_count=0; warm-up counter=0.
// - Mismatch on a beat: |((gold_data ^ gate_data) & ~gold_xmask); one beat counts at most one error.
// - FSM: IDLE -start-> WARMUP (if WARMUP_CYC>0) else RUN; WARMUP -WARMUP_CYC valid beats-> RUN;
//   RUN -stop, or err_count reaching FAIL_LIMIT-> DONE; DONE -start-> WARMUP/RUN.
// - start clears both counters, fail, pass and done in the same edge; start while busy is ignored.
// - stop in WARMUP -> DONE with cmp_count=0 and pass=1; stop in IDLE/DONE ignored.
// - Same-cycle stop and cmp_vld in RUN: the beat is compared and counted, then DONE.
// - Same-cycle start and stop in IDLE/DONE: start wins; stop ignored.
// - Counters and warm-up counter advance only on cmp_vld; gaps in cmp_vld do not count.
// - Latency: counters/fail update 1 cycle after the beat; done/pass 1 cycle after the stop or limit beat.
// - Counters saturate at 2^CNT_W-1; no wrap. A saturated err_count still keeps fail=1.
// - FAIL_LIMIT hit: beat N that makes err_count==FAIL_LIMIT is the last counted; later beats ignored.
// - rst mid-session returns to IDLE with all outputs cleared; no verdict produced.
// CONFIGURATION
// - MITER_FIRST_ERR_EN defined: adds outputs first_err_idx[CNT_W], first_err_gold[WIDTH],
//   first_err_gate[WIDTH], captured on the first mismatching RUN beat (idx = cmp_count before increment);
//   cleared to 0 on rst and start; unchanged by later mismatches.
// - Not defined: those ports and their registers are absent; all other behaviour identical.
// TESTING
// - WARMUP_CYC=4: start, 10 matching valid beats, stop -> cmp_count=6, err_count=0, done=1, pass=1.
// - FAIL_LIMIT=0: mismatch on RUN beats 2 and 5 of 8 -> err_count=2, fail=1 one cycle after beat 2, pass=0 at done.
// - gold_xmask=32'h0000_00FF, gold/gate differ only in bits [7:0] -> no error; differ in bit 8 -> error.
// - FAIL_LIMIT=1: first mismatch -> done=1 next cycle, following beats not counted, cmp_count frozen.
// - CNT_W=4: 20 matching beats -> cmp_count=15 (saturated); rst mid-RUN -> all outputs 0, state IDLE.
// - MITER_FIRST_ERR_EN: mismatches on RUN beats 3 and 7 -> first_err_idx=3, first_err_gold/gate hold beat-3 data.

Source files
------------

// File: rtl/miter_lockstep_checker.sv
// Lockstep miter: compares gold/gate buses beat by beat, counts compares/mismatches, issues a verdict.
// Define MITER_FIRST_ERR_EN to add capture of the first mismatching RUN beat (index, gold, gate).
//
// state  | meaning
// IDLE   | no session, waiting for start
// WARMUP | discarding the first WARMUP_CYC valid beats
// RUN    | comparing and counting valid beats
// DONE   | verdict held until next start
module miter_lockstep_checker #(
   parameter int WIDTH      = 32,
   parameter int CNT_W      = 16,
   parameter int WARMUP_CYC = 4,
   parameter int FAIL_LIMIT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             stop,
   input  logic             cmp_vld,
   input  logic [WIDTH-1:0] gold_data,
   input  logic [WIDTH-1:0] gate_data,
   input  logic [WIDTH-1:0] gold_xmask,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic             fail,
   output logic [CNT_W-1:0] cmp_count,
   output logic [CNT_W-1:0] err_count
`ifdef MITER_FIRST_ERR_EN
   ,
   output logic [CNT_W-1:0] first_err_idx,
   output logic [WIDTH-1:0] first_err_gold,
   output logic [WIDTH-1:0] first_err_gate
`endif
);

   localparam int                WARM_W    = (WARMUP_CYC > 0) ? $clog2(WARMUP_CYC + 1) : 1;
   localparam logic [WARM_W-1:0] WARM_LOAD = WARM_W'(WARMUP_CYC);
   localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
   localparam logic [CNT_W-1:0]  ERR_LIMIT = CNT_W'(FAIL_LIMIT);

   typedef enum logic [1:0] {IDLE, WARMUP, RUN, DONE} state_t;

   state_t            state;
   logic [WARM_W-1:0] warm_cnt;
   logic              mismatch;
   logic              limit_hit;
   logic [CNT_W-1:0]  cmp_next;
   logic [CNT_W-1:0]  err_next;

   assign mismatch  = |((gold_data ^ gate_data) & ~gold_xmask);
   assign cmp_next  = (cmp_count == CNT_MAX) ? cmp_count : cmp_count + 1'b1;
   assign err_next  = (err_count == CNT_MAX) ? err_count : err_count + 1'b1;
   assign limit_hit = (FAIL_LIMIT != 0) && cmp_vld && mismatch && (err_next == ERR_LIMIT);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         warm_cnt  <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         pass      <= 1'b0;
         fail      <= 1'b0;
         cmp_count <= '0;
         err_count <= '0;
`ifdef MITER_FIRST_ERR_EN
         first_err_idx  <= '0;
         first_err_gold <= '0;
         first_err_gate <= '0;
`endif
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  cmp_count <= '0;
                  err_count <= '0;
                  fail      <= 1'b0;
                  pass      <= 1'b0;
                  done      <= 1'b0;
                  busy      <= 1'b1;
`ifdef MITER_FIRST_ERR_EN
                  first_err_idx  <= '0;
                  first_err_gold <= '0;
                  first_err_gate <= '0;
`endif
                  if (WARMUP_CYC > 0) begin
                     state    <= WARMUP;
                     warm_cnt <= WARM_LOAD;
                  end else begin
                     state <= RUN;
                  end
               end
            end
            WARMUP: begin
               // err_count is zero throughout warm-up, so an early stop is always a pass
               if (stop) begin
                  state    <= DONE;
                  warm_cnt <= '0;
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  pass     <= 1'b1;
               end else if (cmp_vld) begin
                  warm_cnt <= warm_cnt - 1'b1;
                  if (warm_cnt == WARM_W'(1)) state <= RUN;
               end
            end
            RUN: begin
               if (cmp_vld) begin
                  cmp_count <= cmp_next;
                  if (mismatch) begin
                     err_count <= err_next;
                     fail      <= 1'b1;
`ifdef MITER_FIRST_ERR_EN
                     if (err_count == '0) begin
                        first_err_idx  <= cmp_count;
                        first_err_gold <= gold_data;
                        first_err_gate <= gate_data;
                     end
`endif
                  end
               end
               if (stop || limit_hit) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  pass  <= (err_count == '0) && !(cmp_vld && mismatch);
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_miter_lockstep_checker.sv
// Bench for miter_lockstep_checker: three parameterisations share one stimulus stream and are
// checked every cycle against a session-level model, plus hand-computed literal expectations.
module tb_miter_lockstep_checker;

   logic        clk = 1'b0;
   logic        rst, start, stop, cmp_vld;
   logic [31:0] gold_data, gate_data, gold_xmask;

   logic        busy0, done0, pass0, fail0;
   logic [15:0] cmp0, err0;
   logic        busy1, done1, pass1, fail1;
   logic [15:0] cmp1, err1;
   logic        busy2, done2, pass2, fail2;
   logic [3:0]  cmp2, err2;
`ifdef MITER_FIRST_ERR_EN
   logic [15:0] fidx0, fidx1;
   logic [3:0]  fidx2;
   logic [31:0] fgold0, fgate0, fgold1, fgate1, fgold2, fgate2;
`endif

   always #5 clk = ~clk;

   // u0: warm-up 4, never stops early; u1: no warm-up, stops on first error; u2: 4-bit counters
   miter_lockstep_checker #(.WIDTH(32), .CNT_W(16), .WARMUP_CYC(4), .FAIL_LIMIT(0)) u0 (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .cmp_vld(cmp_vld),
      .gold_data(gold_data), .gate_data(gate_data), .gold_xmask(gold_xmask),
      .busy(busy0), .done(done0), .pass(pass0), .fail(fail0), .cmp_count(cmp0), .err_count(err0)
`ifdef MITER_FIRST_ERR_EN
      , .first_err_idx(fidx0), .first_err_gold(fgold0), .first_err_gate(fgate0)
`endif
   );
   miter_lockstep_checker #(.WIDTH(32), .CNT_W(16), .WARMUP_CYC(0), .FAIL_LIMIT(1)) u1 (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .cmp_vld(cmp_vld),
      .gold_data(gold_data), .gate_data(gate_data), .gold_xmask(gold_xmask),
      .busy(busy1), .done(done1), .pass(pass1), .fail(fail1), .cmp_count(cmp1), .err_count(err1)
`ifdef MITER_FIRST_ERR_EN
      , .first_err_idx(fidx1), .first_err_gold(fgold1), .first_err_gate(fgate1)
`endif
   );
   miter_lockstep_checker #(.WIDTH(32), .CNT_W(4), .WARMUP_CYC(0), .FAIL_LIMIT(0)) u2 (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .cmp_vld(cmp_vld),
      .gold_data(gold_data), .gate_data(gate_data), .gold_xmask(gold_xmask),
      .busy(busy2), .done(done2), .pass(pass2), .fail(fail2), .cmp_count(cmp2), .err_count(err2)
`ifdef MITER_FIRST_ERR_EN
      , .first_err_idx(fidx2), .first_err_gold(fgold2), .first_err_gate(fgate2)
`endif
   );

   int n_chk = 0;
   int n_err = 0;

   // model: phase 0=idle 1=warm-up 2=run 3=verdict
   int P_WARM [3] = '{4, 0, 0};
   int P_FL   [3] = '{0, 1, 0};
   int P_MAX  [3] = '{65535, 65535, 15};
   int phase  [3];
   int warm   [3];
   int mc     [3];
   int me     [3];
   int mf     [3];
   int mp     [3];
   int fidx   [3];
   int fgold  [3];
   int fgate  [3];

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
      end
   endtask

   task automatic model_step();
      bit mm;
      mm = ((gold_data ^ gate_data) & ~gold_xmask) != 32'd0;
      for (int i = 0; i < 3; i++) begin
         if (rst) begin
            phase[i] = 0; warm[i] = 0; mc[i] = 0; me[i] = 0; mf[i] = 0; mp[i] = 0;
            fidx[i] = 0; fgold[i] = 0; fgate[i] = 0;
         end else begin
            case (phase[i])
               0, 3: if (start) begin
                  mc[i] = 0; me[i] = 0; mf[i] = 0; mp[i] = 0; warm[i] = 0;
                  fidx[i] = 0; fgold[i] = 0; fgate[i] = 0;
                  phase[i] = (P_WARM[i] > 0) ? 1 : 2;
               end
               1: if (stop) begin
                  phase[i] = 3; mp[i] = 1;
               end else if (cmp_vld) begin
                  warm[i]++;
                  if (warm[i] == P_WARM[i]) phase[i] = 2;
               end
               2: begin
                  if (cmp_vld) begin
                     if (mm) begin
                        if (me[i] == 0) begin
                           fidx[i] = mc[i]; fgold[i] = int'(gold_data); fgate[i] = int'(gate_data);
                        end
                        me[i] = (me[i] < P_MAX[i]) ? me[i] + 1 : P_MAX[i];
                        mf[i] = 1;
                     end
                     mc[i] = (mc[i] < P_MAX[i]) ? mc[i] + 1 : P_MAX[i];
                  end
                  if (stop || (P_FL[i] != 0 && cmp_vld && mm && me[i] == P_FL[i])) begin
                     phase[i] = 3; mp[i] = (me[i] == 0) ? 1 : 0;
                  end
               end
               default: ;
            endcase
         end
      end
   endtask

   task automatic cmp_inst(input int i, input logic b, input logic d, input logic p, input logic f,
                           input int c, input int e);
      chk($sformatf("u%0d.busy", i), int'(b), (phase[i] == 1 || phase[i] == 2) ? 1 : 0);
      chk($sformatf("u%0d.done", i), int'(d), (phase[i] == 3) ? 1 : 0);
      chk($sformatf("u%0d.pass", i), int'(p), mp[i]);
      chk($sformatf("u%0d.fail", i), int'(f), mf[i]);
      chk($sformatf("u%0d.cmp_count", i), c, mc[i]);
      chk($sformatf("u%0d.err_count", i), e, me[i]);
   endtask

   task automatic compare_all();
      cmp_inst(0, busy0, done0, pass0, fail0, int'(cmp0), int'(err0));
      cmp_inst(1, busy1, done1, pass1, fail1, int'(cmp1), int'(err1));
      cmp_inst(2, busy2, done2, pass2, fail2, int'(cmp2), int'(err2));
`ifdef MITER_FIRST_ERR_EN
      chk("u0.first_err_idx", int'(fidx0), fidx[0]);
      chk("u0.first_err_gold", int'(fgold0), fgold[0]);
      chk("u0.first_err_gate", int'(fgate0), fgate[0]);
      chk("u1.first_err_idx", int'(fidx1), fidx[1]);
      chk("u1.first_err_gold", int'(fgold1), fgold[1]);
      chk("u1.first_err_gate", int'(fgate1), fgate[1]);
      chk("u2.first_err_idx", int'(fidx2), fidx[2]);
      chk("u2.first_err_gold", int'(fgold2), fgold[2]);
      chk("u2.first_err_gate", int'(fgate2), fgate[2]);
`endif
   endtask

   task automatic cyc(input logic s, input logic p, input logic v,
                      input logic [31:0] g, input logic [31:0] t, input logic [31:0] m);
      start = s; stop = p; cmp_vld = v; gold_data = g; gate_data = t; gold_xmask = m;
      @(posedge clk);
      model_step();
      #1;
      compare_all();
   endtask

   task automatic idle_cyc();
      cyc(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
   endtask

   initial begin
      logic [31:0] g, t;
      rst = 1'b1;
      start = 1'b0; stop = 1'b0; cmp_vld = 1'b0;
      gold_data = '0; gate_data = '0; gold_xmask = '0;
      idle_cyc();
      idle_cyc();
      chk("reset_done", int'(done0), 0);
      chk("reset_busy", int'(busy1), 0);
      rst = 1'b0;

      // A: start, 10 matching beats, stop
      cyc(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
      for (int k = 0; k < 10; k++) cyc(1'b0, 1'b0, 1'b1, 32'h1234_0000 + k, 32'h1234_0000 + k, 32'd0);
      cyc(1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 32'd0);
      chk("litA_u0_cmp", int'(cmp0), 6);
      chk("litA_u0_pass", int'(pass0), 1);
      chk("litA_u1_cmp", int'(cmp1), 10);
      idle_cyc();

      // B: 4 warm-up beats then 8 RUN beats; mismatch (bit 8) on RUN 2 and 5, masked diff on RUN 3
      cyc(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
      for (int k = 0; k < 12; k++) begin
         g = 32'hA000_0000 + k;
         t = g;
         if (k == 6 || k == 9) t = g ^ 32'h0000_0100;
         if (k == 7) t = g ^ 32'h0000_0081;
         cyc(1'b0, 1'b0, 1'b1, g, t, 32'h0000_00FF);
         if (k == 5) chk("litB_u0_fail_before", int'(fail0), 0);
         if (k == 6) chk("litB_u0_fail_after", int'(fail0), 1);
         if (k == 6) chk("litB_u1_done_next", int'(done1), 1);
      end
      chk("litB_u1_cmp_frozen", int'(cmp1), 7);
      chk("litB_u1_err", int'(err1), 1);
      cyc(1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 32'd0);
      chk("litB_u0_err", int'(err0), 2);
      chk("litB_u0_cmp", int'(cmp0), 8);
      chk("litB_u0_pass", int'(pass0), 0);
      chk("litB_u2_err", int'(err2), 2);
`ifdef MITER_FIRST_ERR_EN
      chk("litB_u0_fidx", int'(fidx0), 2);
      chk("litB_u0_fgold", int'(fgold0), 32'hA000_0006);
      chk("litB_u0_fgate", int'(fgate0), 32'hA000_0106);
`endif

      // C: saturation on 4-bit counters, then reset mid-session
      cyc(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
      for (int k = 0; k < 20; k++) begin
         cyc(1'b0, 1'b0, 1'b1, 32'h5555_0000 + k, 32'h5555_0000 + k, 32'd0);
         if (k == 3) idle_cyc();
      end
      chk("litC_u2_cmp_sat", int'(cmp2), 15);
      chk("litC_u0_cmp", int'(cmp0), 16);
      rst = 1'b1;
      idle_cyc();
      rst = 1'b0;
      chk("litC_u2_busy_rst", int'(busy2), 0);
      chk("litC_u2_cmp_rst", int'(cmp2), 0);

      // D: stop in IDLE ignored, start+stop together, start while busy, stop during warm-up
      cyc(1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 32'd0);
      chk("litD_stop_idle", int'(done0), 0);
      cyc(1'b1, 1'b1, 1'b0, 32'd0, 32'd0, 32'd0);
      chk("litD_start_wins", int'(busy0), 1);
      cyc(1'b0, 1'b0, 1'b1, 32'd7, 32'd7, 32'd0);
      cyc(1'b0, 1'b0, 1'b1, 32'd8, 32'd8, 32'd0);
      cyc(1'b1, 1'b0, 1'b1, 32'd9, 32'd9, 32'd0);
      cyc(1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 32'd0);
      chk("litD_u0_warm_stop_pass", int'(pass0), 1);
      chk("litD_u0_warm_stop_cmp", int'(cmp0), 0);
      chk("litD_u1_cmp", int'(cmp1), 3);

      // E: final RUN beat arrives with stop and a mismatch; it is counted
      cyc(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
      for (int k = 0; k < 5; k++) cyc(1'b0, 1'b0, 1'b1, 32'd3, 32'd3, 32'd0);
      cyc(1'b0, 1'b1, 1'b1, 32'hFFFF_0000, 32'h0000_0000, 32'd0);
      chk("litE_u0_cmp", int'(cmp0), 2);
      chk("litE_u0_err", int'(err0), 1);
      chk("litE_u0_pass", int'(pass0), 0);
      idle_cyc();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
